// File: rtl/jk_excitation_sequencer_pkg.sv
// Shared types for the JK excitation sequencer: FSM states, count modes
// and the binary-to-Gray helper.
package jkseq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_DONE,
        ST_ERR
    } state_t;

    typedef enum logic [1:0] {
        MODE_UP     = 2'b00,
        MODE_DOWN   = 2'b01,
        MODE_GRAY   = 2'b10,
        MODE_TOGGLE = 2'b11
    } mode_t;

    // Callers zero-extend narrower values and truncate the result.
    function automatic logic [31:0] gray_code(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/jk_excitation_sequencer_excite.sv
// Per-bit JK excitation: present/next state (or forced toggle) to J/K,
// with the don't-care terms resolved to 0.
module jk_excite (
    input  logic present_bit,
    input  logic next_bit,
    input  logic toggle,
    output logic j,
    output logic k
);

    always_comb begin
        j = toggle | (~present_bit & next_bit);
        k = toggle | (present_bit & ~next_bit);
    end

endmodule

// File: rtl/jk_excitation_sequencer.sv
// Drives a JK flip-flop bank through a programmed count sequence and checks
// its Q feedback. Define JKSEQ_CHECK_EN to build the Q_fb compare/ERR path.
module jk_excitation_sequencer
    import jkseq_pkg::*;
#(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned STEP_W = 8
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic [1:0]        Mode,
    input  logic [WIDTH-1:0]  Load_Value,
    input  logic [STEP_W-1:0] Num_Steps,
    input  logic [WIDTH-1:0]  Q_fb,
    output logic [WIDTH-1:0]  J,
    output logic [WIDTH-1:0]  K,
    output logic [WIDTH-1:0]  Expected,
    output logic              Busy,
    output logic              Done,
    output logic              Mismatch
);

    state_t             state;
    mode_t              mode_r;
    logic [STEP_W-1:0]  steps_r;
    logic [STEP_W-1:0]  remaining;
    logic [WIDTH-1:0]   bin;
    logic [WIDTH-1:0]   load_img, start_img, base, tgt_a, tgt_b, bin_b;
    logic [WIDTH-1:0]   exc_from, exc_to, exc_j, exc_k;
    logic               toggle_all, check_fail, launch;

    function automatic logic [WIDTH-1:0] gray_w(input logic [WIDTH-1:0] b);
        return WIDTH'(gray_code(32'(b)));
    endfunction

    function automatic logic [WIDTH-1:0] target_of(input mode_t m,
                                                   input logic [WIDTH-1:0] b,
                                                   input logic [WIDTH-1:0] prev);
        case (m)
            MODE_UP:   return b + WIDTH'(1);
            MODE_DOWN: return b - WIDTH'(1);
            MODE_GRAY: return gray_w(b + WIDTH'(1));
            default:   return ~prev;
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] step_of(input mode_t m, input logic [WIDTH-1:0] b);
        case (m)
            MODE_UP, MODE_GRAY: return b + WIDTH'(1);
            MODE_DOWN:          return b - WIDTH'(1);
            default:            return b;
        endcase
    endfunction

`ifdef JKSEQ_CHECK_EN
    assign check_fail = (Q_fb != Expected);
`else
    logic unused_q_fb;
    assign unused_q_fb = ^Q_fb;
    assign check_fail  = 1'b0;
`endif

    // tgt_a is the target Expected takes this edge, tgt_b the one after it;
    // J/K are always registered one transition ahead of Expected.
    always_comb begin
        load_img   = (mode_r == MODE_GRAY) ? gray_w(bin) : bin;
        start_img  = (mode_t'(Mode) == MODE_GRAY) ? gray_w(Load_Value) : Load_Value;
        base       = (state == ST_LOAD) ? load_img : Expected;
        tgt_a      = target_of(mode_r, bin, base);
        bin_b      = step_of(mode_r, bin);
        tgt_b      = target_of(mode_r, bin_b, tgt_a);
        exc_from   = (state == ST_LOAD) ? load_img : tgt_a;
        exc_to     = (state == ST_LOAD) ? tgt_a : tgt_b;
        toggle_all = (mode_r == MODE_TOGGLE);
        launch     = Start && ((state == ST_IDLE) || (state == ST_ERR) ||
                               ((state == ST_DONE) && !check_fail));
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        jk_excite u_excite (
            .present_bit (exc_from[i]),
            .next_bit    (exc_to[i]),
            .toggle      (toggle_all),
            .j           (exc_j[i]),
            .k           (exc_k[i])
        );
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state     <= ST_IDLE;
            mode_r    <= MODE_UP;
            steps_r   <= '0;
            remaining <= '0;
            bin       <= '0;
            J         <= '0;
            K         <= '0;
            Expected  <= '0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            Mismatch  <= 1'b0;
        end else begin
            Done <= 1'b0;
            if (launch) begin
                state    <= ST_LOAD;
                mode_r   <= mode_t'(Mode);
                steps_r  <= Num_Steps;
                bin      <= Load_Value;
                Mismatch <= 1'b0;
                Busy     <= 1'b1;
                J        <= start_img;
                K        <= ~start_img;
            end else begin
                case (state)
                    ST_LOAD: begin
                        Expected  <= load_img;
                        remaining <= steps_r;
                        if (steps_r == '0) begin
                            state <= ST_DONE;
                            J     <= '0;
                            K     <= '0;
                            Busy  <= 1'b0;
                            Done  <= 1'b1;
                        end else begin
                            state <= ST_RUN;
                            J     <= exc_j;
                            K     <= exc_k;
                        end
                    end
                    ST_RUN: begin
                        if (check_fail) begin
                            state    <= ST_ERR;
                            Mismatch <= 1'b1;
                            J        <= '0;
                            K        <= '0;
                            Busy     <= 1'b0;
                        end else begin
                            Expected  <= tgt_a;
                            bin       <= bin_b;
                            remaining <= remaining - STEP_W'(1);
                            if (remaining == STEP_W'(1)) begin
                                state <= ST_DONE;
                                J     <= '0;
                                K     <= '0;
                                Busy  <= 1'b0;
                                Done  <= 1'b1;
                            end else begin
                                J <= exc_j;
                                K <= exc_k;
                            end
                        end
                    end
                    ST_DONE: begin
                        if (check_fail) begin
                            state    <= ST_ERR;
                            Mismatch <= 1'b1;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_jk_excitation_sequencer.sv
// Scoreboard bench: randomized sequences against a closed-form count model,
// with an ideal JK bank (optional stuck-at-0 bits) on Q_fb.
module tb_jk_excitation_sequencer;

    localparam int unsigned W   = 4;
    localparam int unsigned SW  = 8;
    localparam int unsigned MOD = 1 << W;

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic          Start = 1'b0;
    logic [1:0]    Mode = '0;
    logic [W-1:0]  Load_Value = '0;
    logic [SW-1:0] Num_Steps = '0;
    logic [W-1:0]  Q_fb, J, K, Expected;
    logic          Busy, Done, Mismatch;

    logic [W-1:0]  bank_q = '0;
    logic [W-1:0]  stuck0_mask = '0;
    logic [W-1:0]  prev_exp = '0;

    typedef struct packed {
        logic         busy;
        logic         done;
        logic         mm;
        logic [W-1:0] j;
        logic [W-1:0] k;
        logic [W-1:0] ex;
    } rec_t;

    rec_t        sb[$];
    rec_t        mon_exp, mon_got;
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    jk_excitation_sequencer #(.WIDTH(W), .STEP_W(SW)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Start      (Start),
        .Mode       (Mode),
        .Load_Value (Load_Value),
        .Num_Steps  (Num_Steps),
        .Q_fb       (Q_fb),
        .J          (J),
        .K          (K),
        .Expected   (Expected),
        .Busy       (Busy),
        .Done       (Done),
        .Mismatch   (Mismatch)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) bank_q <= (J & ~bank_q) | (~K & bank_q);
    assign Q_fb = bank_q & ~stuck0_mask;

    // k-th state of the programmed sequence (k=0 is the load image).
    function automatic logic [W-1:0] seq_val(input logic [1:0] m, input logic [W-1:0] l,
                                             input int unsigned k);
        int unsigned v;
        case (m)
            2'd0:    v = (32'(l) + k) % MOD;
            2'd1:    v = (32'(l) + MOD - (k % MOD)) % MOD;
            2'd2:    begin v = (32'(l) + k) % MOD; v = v ^ (v >> 1); end
            default: v = (k % 2 == 0) ? 32'(l) : 32'(~l);
        endcase
        return W'(v);
    endfunction

    // Pushes every cycle of the window in which the DUT should present
    // Busy, Done or Mismatch; window spans n+2+g cycles from the Start edge.
    task automatic push_txn(input logic [1:0] m, input logic [W-1:0] l, input int unsigned n,
                            input int unsigned g, input logic [W-1:0] mask);
        int   kf;
        rec_t r;
        logic [W-1:0] a, b;
        kf = -1;
`ifdef JKSEQ_CHECK_EN
        for (int unsigned k = 0; k <= n; k++)
            if (kf < 0 && (seq_val(m, l, k) & mask) != '0) kf = int'(k);
`endif
        for (int unsigned c = 0; c <= n + 1 + g; c++) begin
            r = '0;
            if (kf >= 0 && int'(c) >= kf + 2) begin
                r.mm = 1'b1;
                r.ex = seq_val(m, l, unsigned'(kf));
                sb.push_back(r);
            end else if (c == 0) begin
                r.busy = 1'b1;
                r.j    = seq_val(m, l, 0);
                r.k    = ~seq_val(m, l, 0);
                r.ex   = prev_exp;
                sb.push_back(r);
            end else if (c <= n) begin
                a      = seq_val(m, l, c - 1);
                b      = seq_val(m, l, c);
                r.busy = 1'b1;
                r.j    = (m == 2'd3) ? '1 : (~a & b);
                r.k    = (m == 2'd3) ? '1 : (a & ~b);
                r.ex   = a;
                sb.push_back(r);
            end else if (c == n + 1) begin
                r.done = 1'b1;
                r.ex   = seq_val(m, l, n);
                sb.push_back(r);
            end
        end
        prev_exp = (kf >= 0) ? seq_val(m, l, unsigned'(kf)) : seq_val(m, l, n);
    endtask

    task automatic run_txn(input logic [1:0] m, input logic [W-1:0] l, input int unsigned n,
                           input int unsigned g, input logic [W-1:0] mask, input bit noise);
        push_txn(m, l, n, g, mask);
        Start      = 1'b1;
        Mode       = m;
        Load_Value = l;
        Num_Steps  = SW'(n);
        @(posedge Clk); #1;
        stuck0_mask = mask;
        Start = 1'b0;
        for (int unsigned i = 0; i < n + 1 + g; i++) begin
            if (noise && i <= n) begin
                Start      = 1'($urandom_range(0, 1));
                Mode       = 2'($urandom);
                Load_Value = W'($urandom);
                Num_Steps  = SW'($urandom);
            end else begin
                Start = 1'b0;
            end
            @(posedge Clk); #1;
        end
        Start = 1'b0;
    endtask

    always @(negedge Clk) begin
        if (Reset && (Busy || Done || Mismatch)) begin
            n_cmp++;
            mon_got = {Busy, Done, Mismatch, J, K, Expected};
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_output t=%0t got busy=%b done=%b mm=%b j=%h k=%h exp=%h, want nothing presented",
                         $time, Busy, Done, Mismatch, J, K, Expected);
            end else begin
                mon_exp = sb.pop_front();
                if (mon_got !== mon_exp) begin
                    n_bad++;
                    $display("FAIL cycle_check t=%0t got busy=%b done=%b mm=%b j=%h k=%h exp=%h, want busy=%b done=%b mm=%b j=%h k=%h exp=%h",
                             $time, mon_got.busy, mon_got.done, mon_got.mm, mon_got.j, mon_got.k, mon_got.ex,
                             mon_exp.busy, mon_exp.done, mon_exp.mm, mon_exp.j, mon_exp.k, mon_exp.ex);
                end
            end
        end
    end

    task automatic check_zero(input string name);
        n_cmp++;
        if ({J, K, Expected, Busy, Done, Mismatch} !== '0) begin
            n_bad++;
            $display("FAIL %s t=%0t got j=%h k=%h exp=%h busy=%b done=%b mm=%b, want all zero",
                     name, $time, J, K, Expected, Busy, Done, Mismatch);
        end
    endtask

    initial begin
        logic [W-1:0] mask;
        int unsigned  g;
        #2 Reset = 1'b0;
        #1 check_zero("reset_state");
        #19 Reset = 1'b1;
        @(posedge Clk); #1;

        run_txn(2'd0, 4'hE, 3, 2, 4'h0, 1'b0);
        run_txn(2'd2, 4'd3, 2, 1, 4'h0, 1'b0);
        run_txn(2'd3, 4'h5, 2, 0, 4'h0, 1'b0);
        run_txn(2'd1, 4'h1, 3, 1, 4'h0, 1'b1);
        run_txn(2'd0, 4'h0, 4, 2, 4'h1, 1'b0);
        run_txn(2'd0, 4'h9, 0, 1, 4'h0, 1'b0);
        run_txn(2'd2, 4'hF, 3, 2, 4'h0, 1'b0);

        // Asynchronous reset in the middle of a run.
        push_txn(2'd0, 4'h2, 8, 0, 4'h0);
        Start = 1'b1; Mode = 2'd0; Load_Value = 4'h2; Num_Steps = SW'(8);
        @(posedge Clk); #1;
        Start = 1'b0;
        repeat (4) begin @(posedge Clk); #1; end
        sb.delete();
        #2 Reset = 1'b0;
        #1 check_zero("async_reset");
        #10 Reset = 1'b1;
        prev_exp = '0;
        @(posedge Clk); #1;
        run_txn(2'd1, 4'h0, 2, 1, 4'h0, 1'b0);

        for (int unsigned t = 0; t < 40; t++) begin
            mask = ($urandom_range(0, 5) == 0) ? W'($urandom_range(1, 15)) : '0;
            g    = (mask != '0) ? 2 : $urandom_range(0, 2);
            run_txn(2'($urandom), W'($urandom), $urandom_range(0, 9), g, mask,
                    (mask == '0) && ($urandom_range(0, 1) == 1));
        end

        repeat (3) begin @(posedge Clk); #1; end
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL sb_drain got %0d pending records, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/jk_excitation_sequencer.md
# jk_excitation_sequencer

Drives a WIDTH-bit bank of JK flip-flops through a programmed count sequence by generating per-bit J/K excitation, then reads the bank's Q back and flags any divergence from the expected state. It is the driving end of the JK flip-flop interface: the flip-flops consume J/K, and this block produces them from desired state transitions. It sits beside a JKFlipFlop bank in lab/exercise designs as a self-checking stimulus source.

## Interface
- WIDTH, 4: bits in the driven JK bank.
- STEP_W, 8: width of the step counter.
- Clk  in  1  rising-edge clock; also clocks the JK bank.
- Reset  in  1  asynchronous, active-low reset.
- Start  in  1  begin a sequence; sampled only in IDLE, ERR, or DONE.
- Mode  in  2  00 binary up, 01 binary down, 10 Gray up, 11 toggle-all; sampled with Start.
- Load_Value  in  WIDTH  initial state; in Gray mode, binary index of the start code.
- Num_Steps  in  STEP_W  transitions to issue; sampled with Start.
- Q_fb  in  WIDTH  Q outputs fed back from the JK bank.
- J, K  out  WIDTH each  registered excitation to the bank.
- Expected  out  WIDTH  state the bank should hold now.
- Busy  out  1  high in LOAD and RUN.
- Done  out  1  one-cycle pulse in DONE.
- Mismatch  out  1  sticky compare failure.

## Operation
- States:
  - IDLE: J=K=0.
  - LOAD: J=Load image, K=~Load image. In Gray mode the load image is gray(Load_Value).
  - RUN
  - DONE: J=K=0.
  - ERR: J=K=0.
- IDLE/DONE/ERR + Start -> LOAD. Mismatch clears, Mode and Num_Steps latch, and an internal binary counter bin loads Load_Value.
- LOAD -> RUN, or -> DONE if Num_Steps=0.
  - Expected <= load image.
  - Remaining <= Num_Steps.
  - J/K <= excitation for the first transition.
- RUN, each edge:
  - Compare Q_fb against Expected.
  - Expected <= target; bin steps.
  - Remaining decrements.
  - J/K <= excitation toward the next target.
  - When Remaining reaches 0, go to DONE with J=K=0.
- DONE:
  - Final compare.
  - Done=1 for one cycle.
  - Then IDLE, unless Start is high, which goes to LOAD.
- Compare failure in RUN or DONE: Mismatch <= 1 and state -> ERR. ERR holds until Start.
- Target per mode, arithmetic modulo 2^WIDTH:
  - 00: bin+1, wrapping all-ones to 0.
  - 01: bin-1, wrapping 0 to all-ones.
  - 10: bin+1, output as gray(bin) = bin ^ (bin>>1).
  - 11: ~Expected.
- Excitation per bit, with don't-cares resolved:
  - 0->0: J=0, K=0.
  - 0->1: J=1, K=0.
  - 1->0: J=0, K=1.
  - 1->1: J=0, K=0.
  - Mode 11: J=K=1 on every bit.
- Start while Busy is ignored.
- Mode and Num_Steps changes mid-run are ignored.

## Timing
- Reset values: state IDLE, J=0, K=0, Expected=0, Busy=0, Done=0, Mismatch=0, bin=0, Remaining=0.
- Start at edge E0. LOAD occupies cycle E0..E1. The bank captures the load image at E1.
- The bank captures the k-th target at edge E1+k. It is checked against Q_fb at edge E2+k.
- Busy is high for Num_Steps+1 cycles. Done asserts in the cycle after Busy falls.
- Mismatch rises on the edge where the compare fails. It is visible in the same cycle as state ERR.
- Reset mid-sequence: all outputs return to reset values immediately, independent of Clk.

## Configuration
- JKSEQ_CHECK_EN defined: Q_fb compare, Mismatch, and ERR are present as described.
- JKSEQ_CHECK_EN undefined:
  - Q_fb is unused.
  - Mismatch is tied to 0 and ERR is unreachable.
  - Sequencing and J/K generation are unchanged.

## Structure
- Package jkseq_pkg holds:
  - the state encodings (IDLE, LOAD, RUN, DONE, ERR);
  - the mode constants (MODE_UP, MODE_DOWN, MODE_GRAY, MODE_TOGGLE);
  - a gray-conversion function.
- Sub-module jk_excite: per-bit combinational mapping (present, next, toggle) -> (J, K). It is instantiated WIDTH times via generate.

## Test plan
All tests use WIDTH=4, with an ideal JK bank model on Q_fb.
- Mode 00, Load=4'hE, Steps=3 -> Expected sequence E,F,0,1. The F->0 step drives J=0000, K=1111. Done pulses once; Mismatch=0.
- Mode 10, Load=4'd3, Steps=2 -> Expected 0010 (gray 3), 0110 (gray 4), 0111 (gray 5). Exactly one bit differs per step.
- Mode 11, Load=4'h5, Steps=2 -> J=K=1111 during RUN; Expected 5,A,5.
- Force Q_fb bit0 stuck-at-0, mode 00, Load=0, Steps=4 -> Mismatch rises on the edge checking Expected=1. State goes to ERR with J=K=0; a later Start clears Mismatch.
- Steps=0, Load=4'h9 -> LOAD, then DONE with the check of 9; Done pulses; Busy high for 1 cycle.
- Reset low mid-RUN -> J, K, Busy, and Expected go to 0 asynchronously. Start after release restarts cleanly from LOAD.
